ctrl_bubble_reg: RTL and testbench



---
 rtl/ctrl_pkg.sv | 46 ++++
 rtl/ctrl_bubble_reg_bubble_ctr.sv | 82 ++++++++
 rtl/ctrl_bubble_reg.sv | 79 +++++++
 tb/tb_ctrl_bubble_reg.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the ID/EX control register: field layout, NOP value, FSM encoding.
// Consumed by ctrl_bubble_reg and bubble_ctr.
package ctrl_pkg;

    localparam int unsigned CTRL_W_DEF    = 11;
    localparam int unsigned BUB_CNT_W_DEF = 2;
    localparam int unsigned STATS_W       = 16;

    // Bit positions of each decoded control field inside the bundle
    localparam int unsigned IDX_ALUOP_LO    = 0;
    localparam int unsigned IDX_ALUOP_HI    = 1;
    localparam int unsigned IDX_REGWRITE_LO = 2;
    localparam int unsigned IDX_REGWRITE_HI = 3;
    localparam int unsigned IDX_ALUSRC2     = 4;
    localparam int unsigned IDX_ALUSRC1     = 5;
    localparam int unsigned IDX_MEMTOREG    = 6;
    localparam int unsigned IDX_MEMREAD     = 7;
    localparam int unsigned IDX_MEMWRITE    = 8;
    localparam int unsigned IDX_UBZ         = 9;
    localparam int unsigned IDX_STR_BYTE    = 10;

    localparam logic [CTRL_W_DEF-1:0] NOP_CTRL = '0;

    typedef enum logic {
        IDLE   = 1'b0,
        BUBBLE = 1'b1
    } bub_state_e;

    typedef struct packed {
        logic       str_byte;
        logic       ubz;
        logic       mem_write;
        logic       mem_read;
        logic       mem_to_reg;
        logic       alu_src1;
        logic       alu_src2;
        logic [1:0] reg_write;
        logic [1:0] alu_op;
    } ctrl_bundle_t;

    // Saturating +1 for the bubble statistics counter
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (v == '1) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/ctrl_bubble_reg_bubble_ctr.sv
// Bubble burst sequencer: IDLE/BUBBLE state plus remaining-bubble down-counter.
// inject_c is high on every edge where the datapath register must load a NOP.
module bubble_ctr
    import ctrl_pkg::*;
#(
    parameter int unsigned BUB_CNT_W = BUB_CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 delay,
    input  logic                 bubble_req,
    input  logic [BUB_CNT_W-1:0] bubble_len,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 inject_c,
    output logic                 busy
);

    bub_state_e           state;
    bub_state_e           state_nxt;
    logic [BUB_CNT_W-1:0] cnt;
    logic [BUB_CNT_W-1:0] cnt_nxt;
    logic [BUB_CNT_W-1:0] len_eff_c;

    // Effective burst length; a zero-length request still costs one bubble
    always_comb begin
        len_eff_c = '0;
        if (bubble_req) begin
            len_eff_c = (bubble_len == '0) ? BUB_CNT_W'(1) : bubble_len;
        end else if (delay) begin
            len_eff_c = BUB_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: flush > stall > burst continue/start
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
        end else if (!stall) begin
            case (state)
                IDLE: begin
                    if (len_eff_c > BUB_CNT_W'(1)) begin
                        state_nxt = BUBBLE;
                        cnt_nxt   = len_eff_c - BUB_CNT_W'(1);
                    end
                end
                BUBBLE: begin
                    cnt_nxt = cnt - BUB_CNT_W'(1);
                    if (cnt == BUB_CNT_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy     = (state == BUBBLE);
        inject_c = 1'b0;
        if (!flush && !stall) begin
            inject_c = (state == BUBBLE) || (len_eff_c != '0);
        end
    end

endmodule

// File: rtl/ctrl_bubble_reg.sv
// Registered ID/EX control stage with stall hold, flush squash and multi-cycle NOP bursts.
// Optional macro CTRL_BUBBLE_STATS_EN adds stats_clr / bubble_count (saturating injected-NOP count).
module ctrl_bubble_reg
    import ctrl_pkg::*;
#(
    parameter int unsigned       CTRL_W    = CTRL_W_DEF,
    parameter int unsigned       BUB_CNT_W = BUB_CNT_W_DEF,
    parameter logic [CTRL_W-1:0] NOP_VALUE = {CTRL_W{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CTRL_W-1:0]    ctrl_in,
    input  logic                 valid_in,
    input  logic                 delay,
    input  logic                 bubble_req,
    input  logic [BUB_CNT_W-1:0] bubble_len,
    input  logic                 stall,
    input  logic                 flush,
    output logic [CTRL_W-1:0]    ctrl_out,
    output logic                 valid_out,
    output logic                 busy
`ifdef CTRL_BUBBLE_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [STATS_W-1:0]   bubble_count
`endif
);

    logic inject_c;

    bubble_ctr #(
        .BUB_CNT_W (BUB_CNT_W)
    ) u_bubble_ctr (
        .clk        (clk),
        .rst        (rst),
        .delay      (delay),
        .bubble_req (bubble_req),
        .bubble_len (bubble_len),
        .stall      (stall),
        .flush      (flush),
        .inject_c   (inject_c),
        .busy       (busy)
    );

    // ID/EX control register; an idle slot is forced to NOP so no X reaches EX
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_out  <= NOP_VALUE;
            valid_out <= 1'b0;
        end else if (flush) begin
            ctrl_out  <= NOP_VALUE;
            valid_out <= 1'b0;
        end else if (!stall) begin
            if (inject_c) begin
                ctrl_out  <= NOP_VALUE;
                valid_out <= 1'b0;
            end else begin
                ctrl_out  <= valid_in ? ctrl_in : NOP_VALUE;
                valid_out <= valid_in;
            end
        end
    end

`ifdef CTRL_BUBBLE_STATS_EN
    // Counts hazard/burst NOPs only; flush squashes and stall holds are excluded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_count <= '0;
        end else if (stats_clr) begin
            bubble_count <= '0;
        end else if (inject_c) begin
            bubble_count <= sat_inc(bubble_count);
        end
    end
`else
    // Statistics not built: inject_c only steers the control register
`endif

endmodule

// File: tb/tb_ctrl_bubble_reg.sv
// Self-checking bench for ctrl_bubble_reg: directed scenarios plus randomized traffic
// compared against a remaining-bubbles reference model.
module tb_ctrl_bubble_reg;

    localparam int unsigned CW = 11;
    localparam int unsigned BW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] ctrl_in;
    logic          valid_in;
    logic          delay;
    logic          bubble_req;
    logic [BW-1:0] bubble_len;
    logic          stall;
    logic          flush;
    logic [CW-1:0] ctrl_out;
    logic          valid_out;
    logic          busy;
`ifdef CTRL_BUBBLE_STATS_EN
    logic          stats_clr;
    logic [15:0]   bubble_count;
    int            m_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: output register contents and number of NOPs still owed
    logic [CW-1:0] m_ctrl;
    logic          m_valid;
    int            m_rem;

    ctrl_bubble_reg #(
        .CTRL_W    (CW),
        .BUB_CNT_W (BW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_in    (ctrl_in),
        .valid_in   (valid_in),
        .delay      (delay),
        .bubble_req (bubble_req),
        .bubble_len (bubble_len),
        .stall      (stall),
        .flush      (flush),
        .ctrl_out   (ctrl_out),
        .valid_out  (valid_out),
        .busy       (busy)
`ifdef CTRL_BUBBLE_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .bubble_count (bubble_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ctrl  = '0;
        m_valid = 1'b0;
        m_rem   = 0;
`ifdef CTRL_BUBBLE_STATS_EN
        m_cnt   = 0;
`endif
    endtask

    task automatic model_edge();
        int len;
        bit inj;
        inj = 1'b0;
        if (bubble_req) len = (bubble_len == 0) ? 1 : int'(bubble_len);
        else if (delay) len = 1;
        else            len = 0;
        if (rst) begin
            model_reset();
            return;
        end
        if (flush) begin
            m_ctrl = '0; m_valid = 1'b0; m_rem = 0;
        end else if (stall) begin
            // everything holds
        end else if (m_rem > 0) begin
            m_ctrl = '0; m_valid = 1'b0; m_rem = m_rem - 1; inj = 1'b1;
        end else if (len > 0) begin
            m_ctrl = '0; m_valid = 1'b0; m_rem = len - 1; inj = 1'b1;
        end else begin
            m_ctrl  = valid_in ? ctrl_in : '0;
            m_valid = valid_in;
        end
`ifdef CTRL_BUBBLE_STATS_EN
        if (stats_clr) m_cnt = 0;
        else if (inj && m_cnt < 65535) m_cnt = m_cnt + 1;
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input logic vi, input logic [CW-1:0] ci, input logic d,
                          input logic br, input logic [BW-1:0] bl, input logic s, input logic f);
        valid_in = vi; ctrl_in = ci; delay = d; bubble_req = br; bubble_len = bl;
        stall = s; flush = f;
    endtask

    task automatic idle_cycles();
        set_in(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
`ifdef CTRL_BUBBLE_STATS_EN
        stats_clr = 1'b0;
`endif
        set_in(1'b1, 11'h7FF, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        model_reset();
        repeat (2) step();
        total++; if (ctrl_out !== 11'h000) begin bad++; $display("FAIL reset_ctrl got=%h want=000", ctrl_out); end
        total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst = 1'b0;
        idle_cycles();
    endtask

    task automatic test_single_delay();
        set_in(1'b1, 11'h3F1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        step();
        total++; if (ctrl_out !== 11'h000 || valid_out !== 1'b0) begin bad++; $display("FAIL delay_nop got=%h/%b want=000/0", ctrl_out, valid_out); end
        delay = 1'b0;
        step();
        total++; if (ctrl_out !== 11'h3F1 || valid_out !== 1'b1) begin bad++; $display("FAIL delay_pass got=%h/%b want=3f1/1", ctrl_out, valid_out); end
    endtask

    task automatic test_reset_mid_burst();
        idle_cycles();
        set_in(1'b1, 11'h5A5, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        step();
        total++; if (valid_out !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rmb_bub1 got=%b/%b want=0/1", valid_out, busy); end
        bubble_req = 1'b0;
        step();
        total++; if (valid_out !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rmb_bub2 got=%b/%b want=0/1", valid_out, busy); end
        rst = 1'b1;
        model_reset();
        #1;
        total++; if (ctrl_out !== 11'h000 || valid_out !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rmb_async got=%h/%b/%b want=000/0/0", ctrl_out, valid_out, busy); end
        rst = 1'b0;
        step();
        total++; if (ctrl_out !== 11'h5A5 || valid_out !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rmb_resume got=%h/%b/%b want=5a5/1/0", ctrl_out, valid_out, busy); end
    endtask

    task automatic test_stall_burst();
        idle_cycles();
        set_in(1'b1, 11'h123, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        step();
        total++; if (valid_out !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL stall_bub1 got=%b/%b want=0/1", valid_out, busy); end
        bubble_req = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (ctrl_out !== 11'h000 || valid_out !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL stall_hold%0d got=%h/%b/%b want=000/0/1", i, ctrl_out, valid_out, busy); end
        end
        stall = 1'b0;
        step();
        total++; if (valid_out !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL stall_bub2 got=%b/%b want=0/1", valid_out, busy); end
        step();
        total++; if (valid_out !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stall_bub3 got=%b/%b want=0/0", valid_out, busy); end
        step();
        total++; if (ctrl_out !== 11'h123 || valid_out !== 1'b1) begin bad++; $display("FAIL stall_pass got=%h/%b want=123/1", ctrl_out, valid_out); end
        ctrl_in = 11'h456;
        stall = 1'b1;
        step();
        total++; if (ctrl_out !== 11'h123 || valid_out !== 1'b1) begin bad++; $display("FAIL stall_data_hold got=%h/%b want=123/1", ctrl_out, valid_out); end
        stall = 1'b0;
        step();
        total++; if (ctrl_out !== 11'h456) begin bad++; $display("FAIL stall_data_next got=%h want=456", ctrl_out); end
    endtask

    task automatic test_flush_beats_stall();
        idle_cycles();
        set_in(1'b1, 11'h2AA, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        step();
        flush = 1'b1;
        step();
        total++; if (ctrl_out !== 11'h000 || valid_out !== 1'b0) begin bad++; $display("FAIL flush_data got=%h/%b want=000/0", ctrl_out, valid_out); end
        set_in(1'b1, 11'h155, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_burst_start got=%b want=1", busy); end
        set_in(1'b1, 11'h155, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        step();
        total++; if (ctrl_out !== 11'h000 || valid_out !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL flush_stall got=%h/%b/%b want=000/0/0", ctrl_out, valid_out, busy); end
        stall = 1'b0; flush = 1'b0;
        step();
        total++; if (ctrl_out !== 11'h155 || valid_out !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL flush_no_resume got=%h/%b/%b want=155/1/0", ctrl_out, valid_out, busy); end
    endtask

    task automatic test_edge_lengths();
        idle_cycles();
        set_in(1'b1, 11'h0F0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        step();
        total++; if (valid_out !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL len0_nop got=%b/%b want=0/0", valid_out, busy); end
        bubble_req = 1'b0;
        step();
        total++; if (ctrl_out !== 11'h0F0 || valid_out !== 1'b1) begin bad++; $display("FAIL len0_pass got=%h/%b want=0f0/1", ctrl_out, valid_out); end
        set_in(1'b1, 11'h00F, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
        step();
        total++; if (valid_out !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL dlybr_nop1 got=%b/%b want=0/1", valid_out, busy); end
        delay = 1'b0; bubble_req = 1'b0;
        step();
        total++; if (valid_out !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL dlybr_nop2 got=%b/%b want=0/0", valid_out, busy); end
        step();
        total++; if (ctrl_out !== 11'h00F || valid_out !== 1'b1) begin bad++; $display("FAIL dlybr_pass got=%h/%b want=00f/1", ctrl_out, valid_out); end
        set_in(1'b1, 11'h700, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        step();
        step();
        total++; if (valid_out !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL noext_nop2 got=%b/%b want=0/1", valid_out, busy); end
        step();
        total++; if (valid_out !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL noext_nop3 got=%b/%b want=0/0", valid_out, busy); end
        bubble_req = 1'b0;
        step();
        total++; if (ctrl_out !== 11'h700 || valid_out !== 1'b1) begin bad++; $display("FAIL noext_pass got=%h/%b want=700/1", ctrl_out, valid_out); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            valid_in   = ($urandom_range(0, 3) != 0);
            ctrl_in    = CW'($urandom);
            delay      = ($urandom_range(0, 7) == 0);
            bubble_req = ($urandom_range(0, 7) == 0);
            bubble_len = BW'($urandom);
            stall      = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 15) == 0);
`ifdef CTRL_BUBBLE_STATS_EN
            stats_clr  = ($urandom_range(0, 63) == 0);
`endif
            step();
            total++; if (ctrl_out !== m_ctrl) begin bad++; $display("FAIL rnd_ctrl cyc=%0d got=%h want=%h", i, ctrl_out, m_ctrl); end
            total++; if (valid_out !== m_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", i, valid_out, m_valid); end
            total++; if (busy !== (m_rem > 0)) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", i, busy, (m_rem > 0)); end
`ifdef CTRL_BUBBLE_STATS_EN
            total++; if (bubble_count !== 16'(m_cnt)) begin bad++; $display("FAIL rnd_stats cyc=%0d got=%0d want=%0d", i, bubble_count, m_cnt); end
`endif
        end
`ifdef CTRL_BUBBLE_STATS_EN
        stats_clr = 1'b0;
`endif
    endtask

`ifdef CTRL_BUBBLE_STATS_EN
    task automatic test_stats();
        idle_cycles();
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_in(1'b1, 11'h011, 1'b1, 1'b0, '0, 1'b0, 1'b0);
            step();
            delay = 1'b0;
            step();
        end
        set_in(1'b1, 11'h022, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        step();
        bubble_req = 1'b0;
        repeat (3) step();
        total++; if (bubble_count !== 16'd5) begin bad++; $display("FAIL stats_five got=%0d want=5", bubble_count); end
        set_in(1'b1, 11'h033, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        repeat (2) step();
        total++; if (bubble_count !== 16'd5) begin bad++; $display("FAIL stats_flush got=%0d want=5", bubble_count); end
        stats_clr = 1'b1;
        set_in(1'b1, 11'h044, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        step();
        stats_clr = 1'b0;
        delay = 1'b1;
        repeat (65534) step();
        total++; if (bubble_count !== 16'hFFFE) begin bad++; $display("FAIL stats_preload got=%h want=fffe", bubble_count); end
        set_in(1'b1, 11'h044, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        step();
        bubble_req = 1'b0;
        repeat (3) step();
        total++; if (bubble_count !== 16'hFFFF) begin bad++; $display("FAIL stats_sat got=%h want=ffff", bubble_count); end
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        total++; if (bubble_count !== 16'h0000) begin bad++; $display("FAIL stats_clr got=%h want=0000", bubble_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_delay();
        test_reset_mid_burst();
        test_stall_burst();
        test_flush_beats_stall();
        test_edge_lengths();
        test_random();
`ifdef CTRL_BUBBLE_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
